// File: rtl/instr_fetch_decode_if.sv
// Bus bundle between the fetch/decode controller, its instruction memory and
// the ALU/register-file datapath.
interface instr_fetch_decode_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] imem_addr;
  logic [7:0]      imem_data;
  logic [7:0]      f;
  logic            ovf;
  logic            take_branch;
  logic            wr_en;
  logic [1:0]      wr_addr;
  logic [8:0]      wr_data;
  logic [1:0]      rd0_addr;
  logic [1:0]      rd1_addr;
  logic [1:0]      alusrc1;
  logic [1:0]      alusrc2;
  logic [7:0]      instr_i;
  logic [2:0]      s;

  modport master (
    output imem_addr, wr_en, wr_addr, wr_data, rd0_addr, rd1_addr,
           alusrc1, alusrc2, instr_i, s,
    input  imem_data, f, ovf, take_branch
  );

  modport slave (
    input  imem_addr, wr_en, wr_addr, wr_data, rd0_addr, rd1_addr,
           alusrc1, alusrc2, instr_i, s,
    output imem_data, f, ovf, take_branch
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Multi-cycle fetch/decode/sequencing controller: fetches 1- or 2-byte
// instructions, steers the datapath, writes back {ovf,f} and resolves branches.
module instr_fetch_decode #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_run,
  output logic                 o_busy,
  instr_fetch_decode_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_IMM_REQ = 3'd3,
    S_IMM_LAT = 3'd4,
    S_EXEC    = 3'd5,
    S_WB      = 3'd6
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [7:0]      r_ir;
  logic [7:0]      r_imm;
  logic [8:0]      r_res;
  logic            r_tb;
  logic [PC_W-1:0] r_imem_addr;
  logic            r_wr_en;
  logic [1:0]      r_wr_addr;
  logic [1:0]      r_rd0_addr;
  logic [1:0]      r_rd1_addr;
  logic [1:0]      r_alusrc1;
  logic [1:0]      r_alusrc2;
  logic [2:0]      r_s;
  logic            r_busy;

  logic [7:0]      w_ir;
  logic            w_is_br;
  logic            w_two;
  logic [PC_W-1:0] w_imm_pc;
  logic [1:0]      w_alusrc1;
  logic [1:0]      w_alusrc2;

  // In DECODE the instruction is still on the memory bus, one edge before it lands in r_ir.
  assign w_ir      = (r_state == S_DECODE) ? bus.imem_data : r_ir;
  assign w_is_br   = (w_ir[7:6] == 2'b11);
  assign w_two     = w_is_br || w_ir[0];
  assign w_imm_pc  = PC_W'(r_imm);
  assign w_alusrc1 = (!w_is_br && w_ir[0] && (w_ir[7:5] == 3'd0)) ? 2'd1 : 2'd0;
  assign w_alusrc2 = (!w_is_br && w_ir[0]) ? 2'd1 : 2'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_IDLE: begin
        if (i_run) w_state_nxt = S_FETCH;
        else       w_state_nxt = S_IDLE;
      end
      S_FETCH: w_state_nxt = S_DECODE;
      S_DECODE: begin
        w_pc_nxt = r_pc + PC_ONE;
        if (w_two) w_state_nxt = S_IMM_REQ;
        else       w_state_nxt = S_EXEC;
      end
      S_IMM_REQ: w_state_nxt = S_IMM_LAT;
      S_IMM_LAT: begin
        w_pc_nxt    = r_pc + PC_ONE;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: w_state_nxt = S_WB;
      S_WB: begin
        if (w_is_br && r_tb) w_pc_nxt = w_imm_pc;
        else                 w_pc_nxt = r_pc;
        if (i_run) w_state_nxt = S_FETCH;
        else       w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath-facing registers; every output is loaded one edge ahead of the state that uses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_ir        <= 8'h00;
      r_imm       <= 8'h00;
      r_res       <= 9'h000;
      r_tb        <= 1'b0;
      r_imem_addr <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= 2'd0;
      r_rd0_addr  <= 2'd0;
      r_rd1_addr  <= 2'd0;
      r_alusrc1   <= 2'd0;
      r_alusrc2   <= 2'd0;
      r_s         <= 3'd0;
      r_busy      <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_wr_en <= (w_state_nxt == S_WB) && !w_is_br;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (r_state == S_DECODE) begin
        r_ir <= bus.imem_data;
      end
      if (r_state == S_IMM_LAT) begin
        r_imm <= bus.imem_data;
      end
      if (r_state == S_EXEC) begin
        r_res <= {bus.ovf, bus.f};
        r_tb  <= bus.take_branch;
      end
      if ((w_state_nxt == S_FETCH) || (w_state_nxt == S_IMM_REQ)) begin
        r_imem_addr <= w_pc_nxt;
      end
      if (w_state_nxt == S_EXEC) begin
        r_rd0_addr <= w_ir[4:3];
        r_rd1_addr <= w_ir[2:1];
        r_wr_addr  <= w_ir[4:3];
        r_s        <= w_ir[7:5];
        r_alusrc1  <= w_alusrc1;
        r_alusrc2  <= w_alusrc2;
      end
    end
  end

  assign bus.imem_addr = r_imem_addr;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_res;
  assign bus.rd0_addr  = r_rd0_addr;
  assign bus.rd1_addr  = r_rd1_addr;
  assign bus.alusrc1   = r_alusrc1;
  assign bus.alusrc2   = r_alusrc2;
  assign bus.instr_i   = r_imm;
  assign bus.s         = r_s;
  assign o_busy        = r_busy;

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Multi-cycle fetch/decode/sequencing controller directly upstream of the ALU/register-file datapath.
- Fetches 8-bit instructions from a synchronous-read instruction memory and decodes them.
- Drives the datapath's read/write addresses, ALU select `s`, operand-source selects and immediate.
- Performs write-back of `{ovf,f}` and resolves BEQ/BNE using the datapath's `take_branch`.

Parameters:
- PC_W, 8, program counter / instruction memory address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  enables execution; sampled in IDLE and at the end of WB.
- imem_addr  out  PC_W  instruction memory address.
- imem_data  in  8  instruction memory read data, valid the cycle after imem_addr.
- f  in  8  ALU result from datapath.
- ovf  in  1  ALU overflow from datapath.
- take_branch  in  1  branch condition from datapath.
- wr_en  out  1  register-file write enable.
- wr_addr  out  2  register-file write address.
- wr_data  out  9  register-file write data.
- rd0_addr  out  2  read port 0 address.
- rd1_addr  out  2  read port 1 address.
- alusrc1  out  2  operand-1 source: 0 = rd0, 1 = zero.
- alusrc2  out  2  operand-2 source: 0 = rd1, 1 = instr_i.
- instr_i  out  8  immediate byte to datapath.
- s  out  3  ALU op: 0 add, 1 inv, 2 and, 3 or, 4 shr, 5 shl, 6 beq, 7 bne.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Encoding: ir[7:5] = op, ir[4:3] = ra, ir[2:1] = rb, ir[0] = m.
- ALU ops (op 0–5):
  - m = 0: single byte.
  - m = 1: second byte is the immediate.
  - op 0 with m = 1 is LI: alusrc1 = 1, alusrc2 = 1.
  - Other ops with m = 1: alusrc1 = 0, alusrc2 = 1.
  - m = 0: both selects are 0.
- Branch ops (op 6, 7): always two bytes; the second byte is the absolute target. m is ignored.
- Address mapping: rd0_addr = ra, rd1_addr = rb, wr_addr = ra. These are driven from ir in EXEC and WB and hold their value otherwise.
- States: IDLE, FETCH, DECODE, IMM_REQ, IMM_LAT, EXEC, WB.
  - IDLE: go to FETCH when run = 1.
  - FETCH: imem_addr = pc.
  - DECODE: ir <= imem_data; pc <= pc + 1. Go to IMM_REQ if branch or m = 1, else go to EXEC.
  - IMM_REQ: imem_addr = pc.
  - IMM_LAT: imm <= imem_data; pc <= pc + 1. Go to EXEC.
  - EXEC: drive s = op and the selects. At the clock edge: res <= {ovf,f} and tb <= take_branch.
  - WB, ALU op: wr_en = 1, wr_data = res.
  - WB, branch: wr_en = 0; if tb, pc <= imm[PC_W-1:0] (zero-extended when PC_W > 8).
  - End of WB: go to FETCH if run = 1, else IDLE.
- Latency:
  - Single-byte instruction: 4 cycles.
  - Two-byte instruction: 6 cycles.
  - Exactly one wr_en pulse per ALU instruction, lasting one cycle.
- instr_i = imm register; it holds its last value.
- run = 0 mid-instruction does not abort; the controller stops only at an instruction boundary.
- PC wraps modulo 2^PC_W. A two-byte instruction at the top address takes its second byte from address 0.
- wr_en is 0 in every state except WB.
- Reset (asynchronous, any state, including mid-EXEC or mid-WB):
  - state = IDLE, pc = RESET_PC.
  - ir, imm, res, tb, all outputs = 0.
  - wr_en drops immediately; no partial write-back.

Test Plan:
- LI r1,92 (0x09, 0x5C) then LI r2,65 (0x11, 0x41), then ADD r1,r2 (0x0C):
  - LI phases: wr_en pulses with wr_addr = 1, wr_data = 0x05C, then wr_addr = 2, wr_data = 0x041.
  - ADD: exactly 4 cycles after its FETCH, wr_addr = 1, wr_data = 0x09D.
- With r0 = r1 = 24, BEQ r0,r1,0x20 (0xC2, 0x20) at pc 0x10:
  - No wr_en pulse.
  - Next FETCH shows imem_addr = 0x20.
  - Same operands with BNE (0xE2, 0x20): next imem_addr = 0x12.
- LI r0,127 and LI r1,127, then ADD r0,r1: wr_data = {ovf,f} as returned by the datapath, i.e. 0x1FE with ovf = 1.
- PC_W = 8, pc = 0xFF holding 0x0B, address 0x00 holding 0x05:
  - Controller reads address 0x00 for the immediate.
  - Next FETCH imem_addr = 0x01.
- Drop run during EXEC:
  - WB still writes once.
  - Controller enters IDLE with busy = 0.
  - Reassert run: FETCH resumes at the next pc.
- Assert rst = 0 asynchronously during EXEC:
  - wr_en, busy and all outputs go to 0 immediately.
  - pc = RESET_PC.
  - After release with run = 1: imem_addr = RESET_PC in FETCH, no write from the aborted instruction.
